// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD operand sequencer.
//
// Contents:
//   GCD_WIDTH        operand/result width; must match the datapath AB/C buses
//   GCD_SEQ_TIMEOUT  default number of cycles allowed per handshake phase
//   gcd_seq_state_t  sequencer FSM state encoding
//
// Build option: GCD_SEQ_TIMEOUT_EN adds the ERR state to the encoding.
package gcd_pkg;

    localparam int GCD_WIDTH       = 16;
    localparam int GCD_SEQ_TIMEOUT = 1024;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_A_REQ = 4'd1,
        ST_A_REL = 4'd2,
        ST_B_REQ = 4'd3,
        ST_B_REL = 4'd4,
        ST_C_REQ = 4'd5,
        ST_C_REL = 4'd6,
        ST_RESP  = 4'd7
`ifdef GCD_SEQ_TIMEOUT_EN
        ,
        ST_ERR   = 4'd8
`endif
    } gcd_seq_state_t;

endpackage

// File: rtl/gcd_seq_timer.sv
// Phase timer for the GCD operand sequencer.
//
// Counts cycles spent in one handshake phase and flags when the phase has
// lasted LIMIT cycles. Only instantiated when GCD_SEQ_TIMEOUT_EN is defined.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   clear    restart the count (asserted on every state change)
//   enable   count this cycle
//   expired  current cycle is the LIMIT-th cycle of the phase
module gcd_seq_timer #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    // The count holds at the terminal value so expired stays asserted
    // until the owner moves on and clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    // The first cycle of a phase sees count 0, so LIMIT-1 marks the last one.
    assign expired = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/gcd_operand_sequencer.sv
// Host-side sequencer for the GCD datapath operand/result bus.
//
// Accepts an (A, B) pair on a valid/ready request port, drives A then B onto
// the core AB bus with four-phase req/ack handshakes, requests the result,
// captures C and returns it on a valid/ready response port.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   req_valid, req_ready, req_a/b     operand request port
//   core_ab, core_req, core_ack       four-phase bus to the GCD core
//   core_c                            result from the GCD datapath
//   res_valid, res_ready, res_c       response port
//   res_err                           timeout flag (0 unless the option is built)
//
// Build option: GCD_SEQ_TIMEOUT_EN adds a per-phase timeout of TIMEOUT_CYCLES
// cycles that ends the transaction with res_err=1 and res_c=0.
module gcd_operand_sequencer
    import gcd_pkg::*;
#(
    parameter int WIDTH          = GCD_WIDTH,
    parameter int TIMEOUT_CYCLES = GCD_SEQ_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] core_ab,
    output logic             core_req,
    input  logic             core_ack,
    input  logic [WIDTH-1:0] core_c,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_c,
    output logic             res_err
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("gcd_operand_sequencer: TIMEOUT_CYCLES must be at least 2");
    end

    gcd_seq_state_t   state;
    gcd_seq_state_t   next_state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    assign req_ready = (state == ST_IDLE);

`ifdef GCD_SEQ_TIMEOUT_EN
    logic in_handshake;
    logic timed_out;
    logic err_q;

    assign in_handshake = (state == ST_A_REQ) || (state == ST_A_REL) ||
                          (state == ST_B_REQ) || (state == ST_B_REL) ||
                          (state == ST_C_REQ) || (state == ST_C_REL);

    gcd_seq_timer #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (next_state != state),
        .enable  (in_handshake),
        .expired (timed_out)
    );

    assign res_err = err_q;
`else
    assign res_err = 1'b0;
`endif

    // Next-state logic. An ack already high on entry to a REQ state simply
    // counts as an acknowledge on the first cycle.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (req_valid)  next_state = ST_A_REQ;
            ST_A_REQ: if (core_ack)   next_state = ST_A_REL;
            ST_A_REL: if (!core_ack)  next_state = ST_B_REQ;
            ST_B_REQ: if (core_ack)   next_state = ST_B_REL;
            ST_B_REL: if (!core_ack)  next_state = ST_C_REQ;
            ST_C_REQ: if (core_ack)   next_state = ST_C_REL;
            ST_C_REL: if (!core_ack)  next_state = ST_RESP;
            ST_RESP:  if (res_ready)  next_state = ST_IDLE;
`ifdef GCD_SEQ_TIMEOUT_EN
            ST_ERR:   if (res_ready)  next_state = ST_IDLE;
`endif
            default:                  next_state = ST_IDLE;
        endcase
`ifdef GCD_SEQ_TIMEOUT_EN
        // A phase that makes progress in its last allowed cycle is not an error.
        if (in_handshake && timed_out && (next_state == state)) begin
            next_state = ST_ERR;
        end
`endif
    end

    // State, operand latches and all outputs are registered. Outputs are
    // decoded from next_state so they change together with the state and
    // reach the core glitch-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            op_a      <= '0;
            op_b      <= '0;
            core_req  <= 1'b0;
            core_ab   <= '0;
            res_valid <= 1'b0;
            res_c     <= '0;
`ifdef GCD_SEQ_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state <= next_state;

            if ((state == ST_IDLE) && req_valid) begin
                op_a <= req_a;
                op_b <= req_b;
            end

            core_req <= (next_state == ST_A_REQ) ||
                        (next_state == ST_B_REQ) ||
                        (next_state == ST_C_REQ);

            // On the accept edge op_a is not loaded yet, so take A straight
            // from the request port.
            case (next_state)
                ST_A_REQ, ST_A_REL: core_ab <= (state == ST_IDLE) ? req_a : op_a;
                ST_B_REQ, ST_B_REL: core_ab <= op_b;
                default:            core_ab <= '0;
            endcase

            if ((state == ST_C_REQ) && core_ack) begin
                res_c <= core_c;
            end

`ifdef GCD_SEQ_TIMEOUT_EN
            res_valid <= (next_state == ST_RESP) || (next_state == ST_ERR);
            err_q     <= (next_state == ST_ERR);
            if ((next_state == ST_ERR) && (state != ST_ERR)) begin
                res_c <= '0;
            end
`else
            res_valid <= (next_state == ST_RESP);
`endif
        end
    end

endmodule

// File: doc/gcd_operand_sequencer.md
# gcd_operand_sequencer

Host-side end of the GCD datapath's operand/result bus. Accepts an operand pair (A, B) over a valid/ready request port and serialises it onto the 16-bit `AB` bus with a four-phase req/ack handshake, first A, then B. It then requests the result, captures `C`, and returns it over a valid/ready response port. It sits between the system interconnect and the GCD controller/datapath pair.

## Interface
- `WIDTH`, 16, operand/result width; must match datapath `AB`/`C`.
- `TIMEOUT_CYCLES`, 1024, cycles allowed per handshake phase; used only with `GCD_SEQ_TIMEOUT_EN`.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: operand pair offered.
- `req_ready` out 1: sequencer can accept a pair.
- `req_a` in WIDTH: operand A.
- `req_b` in WIDTH: operand B.
- `core_ab` out WIDTH: drives datapath `AB`.
- `core_req` out 1: four-phase request to the GCD core.
- `core_ack` in 1: four-phase acknowledge from the GCD core.
- `core_c` in WIDTH: datapath result `C`.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer takes the result.
- `res_c` out WIDTH: captured GCD.
- `res_err` out 1: result invalid because of a timeout; constant 0 without the macro.

## Operation
- Reset state is IDLE. Reset values: `core_req`=0, `core_ab`=0, `res_valid`=0, `res_c`=0, `res_err`=0. `req_ready`=1 as soon as `reset_n` is high.
- `req_ready` = (state==IDLE). Accept occurs when `req_valid` and `req_ready` are both high; A and B are latched into internal registers at that edge.
- FSM states: IDLE, A_REQ, A_REL, B_REQ, B_REL, C_REQ, C_REL, RESP, plus ERR when the macro is defined.
  - IDLE → A_REQ on accept.
  - A_REQ: `core_ab`=A, `core_req`=1. Leaves for A_REL when `core_ack`=1.
  - A_REL: `core_req`=0, `core_ab` holds A. Leaves for B_REQ when `core_ack`=0.
  - B_REQ / B_REL: same as the A phase, with `core_ab`=B.
  - C_REQ: `core_req`=1, `core_ab`=0. When `core_ack`=1, capture `core_c` into `res_c` and go to C_REL.
  - C_REL: `core_req`=0. When `core_ack`=0, go to RESP.
  - RESP: `res_valid`=1. When `res_ready`=1, clear `res_valid` and return to IDLE.
- `core_req` and `core_ab` are registered outputs, so they are glitch-free toward the core.
- `core_ab` is stable for the whole of a REQ state and the following REL state.
- `res_c` holds its value after the response handshake until the next capture.
- Operands of zero or A==B are forwarded unchanged; the sequencer does no arithmetic.
- If `core_ack` is already high on entry to any REQ state (protocol violation), it counts as an immediate acknowledge. This case is not flagged.
- `req_valid` asserted outside IDLE is ignored and not back-pressured beyond `req_ready`=0.

## Timing
- Each state lasts at least one cycle, because transitions are sampled on the rising edge.
- Best case, with `core_ack` following `core_req` combinationally: accept at cycle 0 gives `core_req`=1 at cycle 1, and `res_valid`=1 at cycle 7.
- `res_valid` holds until `res_ready`. A response handshake at cycle N gives `req_ready`=1 at cycle N+1; there is no accept in the same cycle as the response.
- Reset asserted mid-transaction forces all outputs to their reset values immediately, drops `core_req`, and discards the latched operands.

## Configuration
- `GCD_SEQ_TIMEOUT_EN` defined: a phase counter clears on every state entry and counts while in REQ/REL states.
  - When it reaches `TIMEOUT_CYCLES`, the FSM goes to ERR: `core_req`=0, `res_c`=0, `res_valid`=1, `res_err`=1.
  - ERR → IDLE on `res_ready`.
- `GCD_SEQ_TIMEOUT_EN` undefined: no counter, no ERR state, and `res_err` is tied to 0. The FSM waits indefinitely on `core_ack`.

## Structure
- Shared package `gcd_pkg`:
  - `gcd_seq_state_t` enum.
  - `GCD_WIDTH`=16.
  - Default `GCD_SEQ_TIMEOUT` constant.
- Sub-module `gcd_seq_timer`: loadable phase counter with a terminal-count flag. Instantiated only under the macro.

## Test plan
- Reset mid-A_REQ (`reset_n`=0 with `core_req`=1) → all outputs 0 at once; `req_ready`=1 after release.
- A=48, B=18, with a core model acking one cycle after req → `core_ab` sequence is 48 then 18; `res_c`=6; `res_valid` held until `res_ready`.
- Back-to-back pairs (12, 8) then (0, 5) with `req_valid` held high → second accept only after the first response; results 4 and 5.
- Slow consumer: `res_ready` low for 10 cycles → `res_valid` and `res_c` stable, `req_ready`=0 throughout.
- Macro on, `TIMEOUT_CYCLES`=8, `core_ack` never rises in B_REQ → ERR after 8 cycles; `res_valid`=1, `res_err`=1, `res_c`=0, `core_req`=0.
- Macro off, same stall → FSM stays in B_REQ with `core_req`=1 for 2000 cycles and `res_err`=0.
